logicnet_lut_engine: RTL and testbench

LOGICNET_LUT_ENGINE -- requirements
Module: logicnet_lut_engine

---
 rtl/logicnet_lut_engine.sv | 203 ++++++++++++++++++++
 tb/tb_logicnet_lut_engine.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logicnet_lut_engine.sv
// LogicNet LUT engine: per-neuron truth tables evaluated one neuron per cycle.
// Optional table readback port enabled by defining LOGICNET_READBACK_EN.
module logicnet_lut_engine #(
    parameter  int IN_W    = 6,
    parameter  int OUT_W   = 2,
    parameter  int NEURONS = 4,
    localparam int NI_W    = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [NI_W-1:0]          cfg_neuron,
    input  logic [IN_W-1:0]          cfg_addr,
    input  logic [OUT_W-1:0]         cfg_data,
    output logic                     cfg_ready,
    output logic                     cfg_err,
`ifdef LOGICNET_READBACK_EN
    input  logic                     cfg_re,
    output logic [OUT_W-1:0]         cfg_rdata,
`endif
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NEURONS*IN_W-1:0]  in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NEURONS*OUT_W-1:0] out_data
);

    typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

    state_t                    state_q, state_d;
    logic [NI_W-1:0]           idx_q, idx_d;
    logic [NEURONS*IN_W-1:0]   in_data_q, in_data_d;
    logic                      cfg_err_q, cfg_err_d;
    logic                      accept;
    logic                      last_idx;
    logic                      cfg_bad_neuron;
    logic                      cfg_wr_ok;
    logic                      cfg_rd_ok;
    logic                      cfg_rd_err;

    // Out-of-range neuron indices only exist when NEURONS is not a power of two.
    generate
        if ((1 << NI_W) > NEURONS) begin : g_range_chk
            assign cfg_bad_neuron = (cfg_neuron >= NI_W'(NEURONS));
        end else begin : g_range_full
            assign cfg_bad_neuron = 1'b0;
        end
    endgenerate

    assign accept   = in_valid && in_ready;
    assign last_idx = (idx_q == NI_W'(NEURONS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (last_idx) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = in_valid ? EVAL : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        cfg_ready = (state_q == IDLE);
        in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
        out_valid = (state_q == HOLD);
    end

`ifdef LOGICNET_READBACK_EN
    assign cfg_rd_ok  = cfg_re && cfg_ready && !cfg_bad_neuron;
    assign cfg_rd_err = cfg_re && (!cfg_ready || cfg_bad_neuron);
`else
    assign cfg_rd_ok  = 1'b0;
    assign cfg_rd_err = 1'b0;
`endif

    assign cfg_wr_ok = cfg_we && cfg_ready && !cfg_bad_neuron;

    always_comb begin
        idx_d     = idx_q;
        in_data_d = in_data_q;
        cfg_err_d = cfg_err_q | (cfg_we && (!cfg_ready || cfg_bad_neuron)) | cfg_rd_err;
        if (accept) begin
            idx_d     = '0;
            in_data_d = in_data;
        end else if (state_q == EVAL) begin
            idx_d = idx_q + NI_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            in_data_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            in_data_q <= in_data_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    logic [OUT_W-1:0] rb_word [NEURONS];

    // One table per neuron; the registered read lands directly in the output slice.
    genvar gi;
    generate
        for (gi = 0; gi < NEURONS; gi++) begin : g_neuron
            logic [OUT_W-1:0] lut_mem [2**IN_W];
            logic [OUT_W-1:0] lut_q;
            logic [OUT_W-1:0] rb_q;
            logic             lut_we;
            logic             lut_re;
            logic             rb_re;

            assign lut_we = cfg_wr_ok && (cfg_neuron == NI_W'(gi));
            assign lut_re = (state_q == EVAL) && (idx_q == NI_W'(gi));
            assign rb_re  = cfg_rd_ok && (cfg_neuron == NI_W'(gi));

            always_ff @(posedge clk) begin
                if (lut_we) begin
                    lut_mem[cfg_addr] <= cfg_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    lut_q <= '0;
                end else if (lut_re) begin
                    lut_q <= lut_mem[in_data_q[gi*IN_W +: IN_W]];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rb_q <= '0;
                end else if (rb_re) begin
                    rb_q <= lut_mem[cfg_addr];
                end
            end

            assign out_data[gi*OUT_W +: OUT_W] = lut_q;
            assign rb_word[gi]                 = rb_q;
        end
    endgenerate

`ifdef LOGICNET_READBACK_EN
    logic [NI_W-1:0] rb_sel_q, rb_sel_d;

    // Remember which neuron was last read so cfg_rdata holds between reads.
    always_comb begin
        rb_sel_d = rb_sel_q;
        if (cfg_rd_ok) begin
            rb_sel_d = cfg_neuron;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rb_sel_q <= '0;
        end else begin
            rb_sel_q <= rb_sel_d;
        end
    end

    assign cfg_rdata = rb_word[rb_sel_q];
`else
    logic rb_unused;
    always_comb begin
        rb_unused = cfg_rd_ok;
        for (int n = 0; n < NEURONS; n++) begin
            rb_unused = rb_unused ^ (^rb_word[n]);
        end
    end
`endif

endmodule

// File: tb/tb_logicnet_lut_engine.sv
// Directed bench for logicnet_lut_engine with a result scoreboard and a table model.
// Exercises the readback port too when LOGICNET_READBACK_EN is defined.
module tb_logicnet_lut_engine;

    localparam int IN_W    = 6;
    localparam int OUT_W   = 2;
    localparam int NEURONS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_neuron = '0;
    logic [5:0]  cfg_addr = '0;
    logic [1:0]  cfg_data = '0;
    logic        cfg_ready, cfg_err;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
`ifdef LOGICNET_READBACK_EN
    logic        cfg_re = 1'b0;
    logic [1:0]  cfg_rdata;
`endif

    // Second instance with a non-power-of-two neuron count for range checks.
    logic        t3_cfg_we = 1'b0;
    logic [1:0]  t3_cfg_neuron = '0;
    logic        t3_cfg_ready, t3_cfg_err, t3_in_ready, t3_out_valid;
    logic [5:0]  t3_out_data;
`ifdef LOGICNET_READBACK_EN
    logic [1:0]  t3_cfg_rdata;
`endif

    int errors = 0;
    int checks = 0;
    logic [1:0] model [NEURONS][64];
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    logicnet_lut_engine #(.IN_W(IN_W), .OUT_W(OUT_W), .NEURONS(NEURONS)) u_dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err),
`ifdef LOGICNET_READBACK_EN
        .cfg_re(cfg_re), .cfg_rdata(cfg_rdata),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    logicnet_lut_engine #(.IN_W(IN_W), .OUT_W(OUT_W), .NEURONS(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .cfg_we(t3_cfg_we), .cfg_neuron(t3_cfg_neuron), .cfg_addr(6'd5), .cfg_data(2'b01),
        .cfg_ready(t3_cfg_ready), .cfg_err(t3_cfg_err),
`ifdef LOGICNET_READBACK_EN
        .cfg_re(1'b0), .cfg_rdata(t3_cfg_rdata),
`endif
        .in_valid(1'b0), .in_ready(t3_in_ready), .in_data(18'd0),
        .out_valid(t3_out_valid), .out_ready(1'b1), .out_data(t3_out_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_of(input logic [23:0] v);
        logic [7:0] r;
        logic [5:0] a;
        r = '0;
        for (int n = 0; n < NEURONS; n++) begin
            a = v[n*6 +: 6];
            r[n*2 +: 2] = model[n][a];
        end
        return r;
    endfunction

    task automatic cfg_write(input int n, input int a, input int d, input bit legal);
        cfg_we     = 1'b1;
        cfg_neuron = n[1:0];
        cfg_addr   = a[5:0];
        cfg_data   = d[1:0];
        step();
        cfg_we = 1'b0;
        if (legal) model[n][a] = d[1:0];
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            step();
            cyc++;
        end
        check("out_valid_arrives", {31'd0, out_valid}, 32'd1);
    endtask

    // Compare the DUT result against the oldest expectation at a handshake edge.
    task automatic sb_pop_check(input string tag);
        logic [7:0] e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s: observed=result expected=empty_scoreboard", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check(tag, {24'd0, out_data}, {24'd0, e});
            $display("txn %s out_data=%02h expected=%02h", tag, out_data, e);
        end
    endtask

    initial begin
        int lat;
        logic [23:0] vec;
        logic [23:0] nxt;
        logic [5:0]  ca;

        // Reset and idle state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);

        // Fill every table with random content, then the directed entries
        for (int n = 0; n < NEURONS; n++)
            for (int a = 0; a < 64; a++)
                cfg_write(n, a, int'($urandom_range(3)), 1'b1);
        cfg_write(1, 0, 0, 1'b1);
        cfg_write(2, 0, 0, 1'b1);
        cfg_write(0, 6'b110000, 2'b11, 1'b1);
        cfg_write(3, 6'b000001, 2'b10, 1'b1);
        check("cfg_err_after_writes", {31'd0, cfg_err}, 32'd0);

        // Directed transaction with fixed latency
        vec = {6'b000001, 6'd0, 6'd0, 6'b110000};
        in_data = vec; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        sb.push_back(exp_of(vec));
        step();
        in_valid = 1'b0;
        check("eval_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        wait_out(lat);
        check("latency_first", lat, 32'd4);
        check("directed_value", {24'd0, out_data}, 32'h83);

        // Backpressure: a pending vector must not be captured while held
        vec = {$urandom} & 24'hFFFFFF;
        in_data = vec; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_out_data", {24'd0, out_data}, 32'h83);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("hold_release_in_ready", {31'd0, in_ready}, 32'd1);
        sb_pop_check("directed");
        sb.push_back(exp_of(vec));
        step();
        in_valid = 1'b0;
        check("b2b_out_valid_drop", {31'd0, out_valid}, 32'd0);
        wait_out(lat);
        check("latency_b2b", lat, 32'd4);
        sb_pop_check("pending_vec");
        step();
        check("back_to_idle", {31'd0, cfg_ready}, 32'd1);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);

        // Write during EVAL to the entry under evaluation is dropped
        vec = {$urandom} & 24'hFFFFFF;
        ca  = vec[5:0];
        sb.push_back(exp_of(vec));
        in_data = vec; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cfg_write(0, int'(ca), int'(~model[0][ca]), 1'b0);
        check("eval_write_err", {31'd0, cfg_err}, 32'd1);
        wait_out(lat);
        sb_pop_check("eval_write_old");
        step();

        // Out-of-range neuron on the three-neuron instance
        check("t3_err_init", {31'd0, t3_cfg_err}, 32'd0);
        t3_cfg_we = 1'b1; t3_cfg_neuron = 2'd2;
        step();
        check("t3_inrange_no_err", {31'd0, t3_cfg_err}, 32'd0);
        t3_cfg_neuron = 2'd3;
        step();
        t3_cfg_we = 1'b0;
        check("t3_outrange_err", {31'd0, t3_cfg_err}, 32'd1);

        // Reset on the second EVAL cycle aborts the transaction
        in_data = {$urandom} & 24'hFFFFFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_out_data", {24'd0, out_data}, 32'd0);
        check("abort_idle", {31'd0, cfg_ready}, 32'd1);
        check("abort_cfg_err", {31'd0, cfg_err}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end

        // Back-to-back random transactions on retained tables
        vec = {$urandom} & 24'hFFFFFF;
        in_data = vec; in_valid = 1'b1; out_ready = 1'b1;
        sb.push_back(exp_of(vec));
        step();
        for (int k = 0; k < 4; k++) begin
            nxt = {$urandom} & 24'hFFFFFF;
            in_data = nxt;
            wait_out(lat);
            check("latency_stream", lat, 32'd4);
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            sb_pop_check("stream");
            if (k < 3) sb.push_back(exp_of(nxt));
            else in_valid = 1'b0;
            step();
            check("stream_valid_drop", {31'd0, out_valid}, 32'd0);
        end
        check("stream_end_idle", {31'd0, cfg_ready}, 32'd1);
        check("sb_drained", sb.size(), 32'd0);

`ifdef LOGICNET_READBACK_EN
        // Readback in IDLE, then an illegal read during EVAL
        cfg_write(2, 6'b101010, 2'b01, 1'b1);
        cfg_re = 1'b1; cfg_neuron = 2'd2; cfg_addr = 6'b101010;
        step();
        cfg_re = 1'b0;
        check("rb_data", {30'd0, cfg_rdata}, 32'd1);
        check("rb_no_err", {31'd0, cfg_err}, 32'd0);
        step();
        check("rb_hold", {30'd0, cfg_rdata}, 32'd1);
        vec = {$urandom} & 24'hFFFFFF;
        sb.push_back(exp_of(vec));
        in_data = vec; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cfg_re = 1'b1; cfg_neuron = 2'd0; cfg_addr = 6'd0;
        step();
        cfg_re = 1'b0;
        check("rb_eval_err", {31'd0, cfg_err}, 32'd1);
        check("rb_eval_unchanged", {30'd0, cfg_rdata}, 32'd1);
        wait_out(lat);
        sb_pop_check("rb_txn");
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
